// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single line-wide memory port.
// A winner's request is latched at grant and held on the memory port until mem_ack_i.
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 256,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              p0_enable_i,
  input  logic              p0_write_i,
  input  logic [ADDR_W-1:0] p0_addr_i,
  input  logic [DATA_W-1:0] p0_data_i,
  output logic              p0_ack_o,
  output logic [DATA_W-1:0] p0_data_o,
  input  logic              p1_enable_i,
  input  logic              p1_write_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic [DATA_W-1:0] p1_data_i,
  output logic              p1_ack_o,
  output logic [DATA_W-1:0] p1_data_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic              busy_o,
  output logic              grant_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  logic              grant;
  logic              last;
  logic              winner;
  logic              mem_enable;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;

  // On a tie, round-robin favours the port that did not win last time.
  always_comb begin
    winner = 1'b0;
    if (p0_enable_i && p1_enable_i) begin
      winner = (FIXED_PRIO != 0) ? 1'b0 : !last;
    end else if (p1_enable_i) begin
      winner = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last       <= 1'b1;
      mem_enable <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_data   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (p0_enable_i || p1_enable_i) begin
            grant      <= winner;
            last       <= winner;
            mem_enable <= 1'b1;
            mem_write  <= winner ? p1_write_i : p0_write_i;
            mem_addr   <= winner ? p1_addr_i  : p0_addr_i;
            mem_data   <= winner ? p1_data_i  : p0_data_i;
            state      <= BUSY;
          end
        end
        BUSY: begin
          if (mem_ack_i) begin
            mem_enable <= 1'b0;
            state      <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          mem_enable <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

  // Ack is combinational so the winner sees it in the same cycle as mem_ack_i.
  assign p0_ack_o     = mem_ack_i && (state == BUSY) && !grant;
  assign p1_ack_o     = mem_ack_i && (state == BUSY) && grant;
  assign p0_data_o    = mem_data_i;
  assign p1_data_o    = mem_data_i;
  assign mem_enable_o = mem_enable;
  assign mem_write_o  = mem_write;
  assign mem_addr_o   = mem_addr;
  assign mem_data_o   = mem_data;
  assign busy_o       = (state == BUSY);
  assign grant_o      = grant;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a round-robin and a fixed-priority instance
// share the same stimulus so tie-breaking of both can be compared side by side.
module tb_mem_arbiter;

  logic         clk;
  logic         rst_n;
  logic         p0_enable, p0_write, p1_enable, p1_write;
  logic [31:0]  p0_addr, p1_addr;
  logic [255:0] p0_data, p1_data;
  logic         mem_ack;
  logic [255:0] mem_rdata;

  logic         rr_p0_ack, rr_p1_ack, rr_mem_enable, rr_mem_write, rr_busy, rr_grant;
  logic [255:0] rr_p0_rdata, rr_p1_rdata, rr_mem_wdata;
  logic [31:0]  rr_mem_addr;
  logic         fp_p0_ack, fp_p1_ack, fp_mem_enable, fp_mem_write, fp_busy, fp_grant;
  logic [255:0] fp_p0_rdata, fp_p1_rdata, fp_mem_wdata;
  logic [31:0]  fp_mem_addr;

  int n_checks = 0;
  int n_fail   = 0;
  logic exp_rr;

  mem_arbiter #(.ADDR_W(32), .DATA_W(256), .FIXED_PRIO(0)) u_rr (
    .clk_i(clk), .rst_i(rst_n),
    .p0_enable_i(p0_enable), .p0_write_i(p0_write), .p0_addr_i(p0_addr), .p0_data_i(p0_data),
    .p0_ack_o(rr_p0_ack), .p0_data_o(rr_p0_rdata),
    .p1_enable_i(p1_enable), .p1_write_i(p1_write), .p1_addr_i(p1_addr), .p1_data_i(p1_data),
    .p1_ack_o(rr_p1_ack), .p1_data_o(rr_p1_rdata),
    .mem_enable_o(rr_mem_enable), .mem_write_o(rr_mem_write), .mem_addr_o(rr_mem_addr),
    .mem_data_o(rr_mem_wdata), .mem_ack_i(mem_ack), .mem_data_i(mem_rdata),
    .busy_o(rr_busy), .grant_o(rr_grant)
  );

  mem_arbiter #(.ADDR_W(32), .DATA_W(256), .FIXED_PRIO(1)) u_fp (
    .clk_i(clk), .rst_i(rst_n),
    .p0_enable_i(p0_enable), .p0_write_i(p0_write), .p0_addr_i(p0_addr), .p0_data_i(p0_data),
    .p0_ack_o(fp_p0_ack), .p0_data_o(fp_p0_rdata),
    .p1_enable_i(p1_enable), .p1_write_i(p1_write), .p1_addr_i(p1_addr), .p1_data_i(p1_data),
    .p1_ack_o(fp_p1_ack), .p1_data_o(fp_p1_rdata),
    .mem_enable_o(fp_mem_enable), .mem_write_o(fp_mem_write), .mem_addr_o(fp_mem_addr),
    .mem_data_o(fp_mem_wdata), .mem_ack_i(mem_ack), .mem_data_i(mem_rdata),
    .busy_o(fp_busy), .grant_o(fp_grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    p0_enable = 0; p0_write = 0; p0_addr = '0; p0_data = '0;
    p1_enable = 0; p1_write = 0; p1_addr = '0; p1_data = '0;
    mem_ack = 0; mem_rdata = '0;
    repeat (3) tick();

    check("rst_mem_enable", rr_mem_enable, 0);
    check("rst_busy",       rr_busy, 0);
    check("rst_grant",      rr_grant, 0);
    check("rst_mem_addr",   rr_mem_addr, 0);
    check("rst_fp_enable",  fp_mem_enable, 0);
    rst_n = 1'b1;
    tick();

    // Single read from port 0, memory answers 10 cycles later
    p0_enable = 1; p0_write = 0; p0_addr = 32'h0;
    tick();
    check("rd_enable", rr_mem_enable, 1);
    check("rd_write",  rr_mem_write, 0);
    check("rd_grant",  rr_grant, 0);
    check("rd_busy",   rr_busy, 1);
    repeat (9) tick();
    check("rd_hold",   rr_mem_enable, 1);
    check("rd_no_ack", rr_p0_ack, 0);
    mem_ack = 1; mem_rdata = 256'h5;
    #1;
    check("rd_ack",    rr_p0_ack, 1);
    check("rd_data",   rr_p0_rdata, 256'h5);
    check("rd_p1_ack", rr_p1_ack, 0);
    tick();
    p0_enable = 0;
    #1;
    check("rd_done_ack",  rr_p0_ack, 0);
    check("rd_done_en",   rr_mem_enable, 0);
    check("rd_done_busy", rr_busy, 0);
    mem_ack = 0;
    tick();

    // Requester inputs change after the grant
    p0_enable = 1; p0_addr = 32'h20;
    tick();
    check("lt_addr", rr_mem_addr, 32'h20);
    p0_addr = 32'h40;
    repeat (3) tick();
    check("lt_hold", rr_mem_addr, 32'h20);
    mem_ack = 1;
    #1;
    check("lt_ack", rr_p0_ack, 1);
    tick();
    mem_ack = 0; p0_enable = 0;
    tick();

    // Single write from port 1
    p1_enable = 1; p1_write = 1; p1_addr = 32'h400; p1_data = 256'hDEAD;
    tick();
    check("wr_write", rr_mem_write, 1);
    check("wr_addr",  rr_mem_addr, 32'h400);
    check("wr_data",  rr_mem_wdata, 256'hDEAD);
    check("wr_grant", rr_grant, 1);
    repeat (2) tick();
    mem_ack = 1;
    #1;
    check("wr_ack",    rr_p1_ack, 1);
    check("wr_p0_ack", rr_p0_ack, 0);
    tick();
    mem_ack = 0; p1_enable = 0; p1_write = 0;
    tick();

    // Both ports request continuously
    p0_enable = 1; p1_enable = 1; p0_addr = 32'h100; p1_addr = 32'h200;
    exp_rr = 1'b0;
    for (int t = 0; t < 4; t++) begin
      tick();
      check("tie_rr_grant", rr_grant, exp_rr);
      check("tie_fp_grant", fp_grant, 0);
      check("tie_rr_addr",  rr_mem_addr, exp_rr ? 32'h200 : 32'h100);
      repeat (2) tick();
      mem_ack = 1;
      #1;
      check("tie_rr_p0_ack", rr_p0_ack, !exp_rr);
      check("tie_rr_p1_ack", rr_p1_ack, exp_rr);
      check("tie_fp_p0_ack", fp_p0_ack, 1);
      check("tie_fp_p1_ack", fp_p1_ack, 0);
      tick();
      mem_ack = 0;
      check("tie_gap_done", rr_mem_enable, 0);
      tick();
      check("tie_gap_idle", rr_mem_enable, 0);
      check("tie_idle_busy", rr_busy, 0);
      exp_rr = !exp_rr;
    end

    // Fixed priority: port 1 only wins when port 0 is idle
    p0_enable = 0;
    tick();
    check("fp_p1_grant", fp_grant, 1);
    check("rr_p1_grant", rr_grant, 1);
    mem_ack = 1;
    #1;
    check("fp_p1_ack", fp_p1_ack, 1);
    check("fp_p0_ack", fp_p0_ack, 0);
    tick();
    mem_ack = 0; p1_enable = 0;
    tick();

    // Reset five cycles into a transaction
    p0_enable = 1; p1_enable = 1;
    tick();
    check("rb_grant", rr_grant, 0);
    repeat (4) tick();
    rst_n = 0; mem_ack = 1;
    #1;
    check("rb_enable", rr_mem_enable, 0);
    check("rb_busy",   rr_busy, 0);
    check("rb_p0_ack", rr_p0_ack, 0);
    check("rb_p1_ack", rr_p1_ack, 0);
    check("rb_fp_en",  fp_mem_enable, 0);
    tick();
    mem_ack = 0; rst_n = 1;
    tick();
    check("rb_tie_grant", rr_grant, 0);
    check("rb_tie_busy",  rr_busy, 1);
    check("rb_tie_en",    rr_mem_enable, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
